axi_sram_slave: RTL and testbench

- AXI4 responder that fronts one single-port synchronous SRAM (data or instruction memory) behind the bus interconnect.
- Accepts one transaction at a time from the interconnect slave port: a read burst or a write burst.
- Drives SRAM chip-enable, write-enable, byte-enable, address and data in; returns read data and write responses.
- It is the far end of the read/write master channels issued by the CPU-side masters.

---
 rtl/axi_sram_slave.sv | 175 +++++++++++++++++
 tb/tb_axi_sram_slave.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sram_slave.sv
// AXI4 slave front end for one single-port synchronous SRAM.
// Handles one read or write burst at a time, INCR word accesses only.
module axi_sram_slave #(
    parameter int ID_W    = 8,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 4,
    parameter int SRAM_AW = 14
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic [ID_W-1:0]     AWID,
    input  logic [ADDR_W-1:0]   AWADDR,
    input  logic [LEN_W-1:0]    AWLEN,
    input  logic [2:0]          AWSIZE,
    input  logic [1:0]          AWBURST,
    input  logic                AWVALID,
    output logic                AWREADY,
    input  logic [DATA_W-1:0]   WDATA,
    input  logic [DATA_W/8-1:0] WSTRB,
    input  logic                WLAST,
    input  logic                WVALID,
    output logic                WREADY,
    output logic [ID_W-1:0]     BID,
    output logic [1:0]          BRESP,
    output logic                BVALID,
    input  logic                BREADY,
    input  logic [ID_W-1:0]     ARID,
    input  logic [ADDR_W-1:0]   ARADDR,
    input  logic [LEN_W-1:0]    ARLEN,
    input  logic [2:0]          ARSIZE,
    input  logic [1:0]          ARBURST,
    input  logic                ARVALID,
    output logic                ARREADY,
    output logic [ID_W-1:0]     RID,
    output logic [DATA_W-1:0]   RDATA,
    output logic [1:0]          RRESP,
    output logic                RLAST,
    output logic                RVALID,
    input  logic                RREADY,
    output logic                SRAM_CEB,
    output logic                SRAM_WEB,
    output logic [DATA_W/8-1:0] SRAM_BWEB,
    output logic [SRAM_AW-1:0]  SRAM_A,
    output logic [DATA_W-1:0]   SRAM_DI,
    input  logic [DATA_W-1:0]   SRAM_DO
);

    typedef enum logic [2:0] {
        IDLE, R_ISSUE, R_DATA, W_DATA, B_RESP
    } state_t;

    localparam logic [SRAM_AW-1:0] A_ONE = 1;
    localparam logic [LEN_W-1:0]   C_ONE = 1;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [SRAM_AW-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;

    logic last;
    logic w_fire;
    logic in_idle;

    // Size, burst type and out-of-window address bits carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{AWSIZE, AWBURST, ARSIZE, ARBURST,
                         AWADDR[ADDR_W-1:SRAM_AW+2], AWADDR[1:0],
                         ARADDR[ADDR_W-1:SRAM_AW+2], ARADDR[1:0]};

    assign last    = (cnt_q == len_q);
    assign w_fire  = (state_q == W_DATA) && WVALID;
    assign in_idle = (state_q == IDLE) && ARESETn;

    // Next-state and burst bookkeeping; read wins a simultaneous request.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (ARVALID) begin
                    id_d    = ARID;
                    addr_d  = ARADDR[SRAM_AW+1:2];
                    len_d   = ARLEN;
                    cnt_d   = '0;
                    state_d = R_ISSUE;
                end else if (AWVALID) begin
                    id_d    = AWID;
                    addr_d  = AWADDR[SRAM_AW+1:2];
                    len_d   = AWLEN;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = W_DATA;
                end
            end
            R_ISSUE: state_d = R_DATA;
            R_DATA: begin
                if (RREADY) begin
                    if (last) begin
                        state_d = IDLE;
                    end else begin
                        addr_d  = addr_q + A_ONE;
                        cnt_d   = cnt_q + C_ONE;
                        state_d = R_ISSUE;
                    end
                end
            end
            W_DATA: begin
                if (WVALID) begin
                    addr_d = addr_q + A_ONE;
                    cnt_d  = cnt_q + C_ONE;
                    err_d  = err_q | (WLAST != last);
                    if (last) state_d = B_RESP;
                end
            end
            B_RESP: begin
                if (BREADY) begin
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and burst registers, cleared asynchronously.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Bus handshakes; gating by ARESETn keeps readies low during reset.
    always_comb begin
        ARREADY = in_idle;
        AWREADY = in_idle && !ARVALID;
        WREADY  = (state_q == W_DATA);
        RVALID  = (state_q == R_DATA);
        RLAST   = RVALID && last;
        RDATA   = RVALID ? SRAM_DO : '0;
        RID     = RVALID ? id_q : '0;
        RRESP   = 2'b00;
        BVALID  = (state_q == B_RESP);
        BID     = BVALID ? id_q : '0;
        BRESP   = (BVALID && err_q) ? 2'b10 : 2'b00;
    end

    // SRAM strobes; CEB stays high in R_DATA so SRAM_DO holds under stall.
    always_comb begin
        SRAM_CEB  = !((state_q == R_ISSUE) || w_fire);
        SRAM_WEB  = !w_fire;
        SRAM_BWEB = w_fire ? ~WSTRB : '1;
        SRAM_A    = addr_q;
        SRAM_DI   = w_fire ? WDATA : '0;
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Randomized bench for axi_sram_slave with an SRAM model
// and a word-array reference memory.
module tb_axi_sram_slave;

    localparam int MAXW = 20;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic [7:0]  AWID, ARID, BID, RID;
    logic [31:0] AWADDR, ARADDR, WDATA, RDATA, SRAM_DI, SRAM_DO;
    logic [3:0]  AWLEN, ARLEN, WSTRB, SRAM_BWEB;
    logic [2:0]  AWSIZE, ARSIZE;
    logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY;
    logic        BVALID, BREADY, ARVALID, ARREADY;
    logic        RLAST, RVALID, RREADY;
    logic        SRAM_CEB, SRAM_WEB;
    logic [13:0] SRAM_A;

    bit [31:0] sram    [0:16383];
    bit [31:0] ref_mem [0:16383];

    int n_tests = 0;
    int n_fail  = 0;
    int aw_wait;
    logic [31:0] last_rdata;
    logic [1:0]  last_bresp;
    int stl [4] = '{0, 2, 0, 1};

    always #5 ACLK = ~ACLK;

    axi_sram_slave dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN),
        .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
        .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN),
        .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
        .RVALID(RVALID), .RREADY(RREADY),
        .SRAM_CEB(SRAM_CEB), .SRAM_WEB(SRAM_WEB),
        .SRAM_BWEB(SRAM_BWEB), .SRAM_A(SRAM_A),
        .SRAM_DI(SRAM_DI), .SRAM_DO(SRAM_DO)
    );

    // Single-port SRAM: read data appears the cycle after an enabled read.
    always @(posedge ACLK) begin
        if (!SRAM_CEB) begin
            if (!SRAM_WEB) begin
                for (int k = 0; k < 4; k++)
                    if (!SRAM_BWEB[k])
                        sram[SRAM_A][8*k +: 8] <= SRAM_DI[8*k +: 8];
            end else begin
                SRAM_DO <= sram[SRAM_A];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_write(input logic [7:0] id, input logic [31:0] addr,
                            input int len, input int wl_beat,
                            input bit fixed, input logic [31:0] d0,
                            input logic [3:0] s0, input bit aw_pre);
        int w, n;
        logic [13:0] wa;
        logic [31:0] d;
        logic [3:0]  s, nb;
        bit err;
        if (!aw_pre) begin
            @(negedge ACLK);
            AWID = id; AWADDR = addr; AWLEN = len[3:0];
            AWSIZE = 3'd2; AWBURST = 2'($urandom); AWVALID = 1'b1;
            #1;
        end
        w = 0;
        while (!AWREADY && w < MAXW) begin
            @(negedge ACLK); #1; w++;
        end
        if (!AWREADY) begin
            chk("awready_timeout", AWREADY, 1);
            AWVALID = 1'b0;
            return;
        end
        aw_wait = w;
        @(negedge ACLK);
        AWVALID = 1'b0;
        wa = addr[15:2];
        err = 1'b0;
        for (int b = 0; b <= len; b++) begin
            if ($urandom_range(0, 3) == 0) begin
                WVALID = 1'b0; #1;
                chk("w_gap_ceb", SRAM_CEB, 1);
                @(negedge ACLK);
            end
            d = fixed ? d0 : $urandom;
            s = fixed ? s0 : 4'($urandom);
            nb = ~s;
            WDATA = d; WSTRB = s; WLAST = (b == wl_beat); WVALID = 1'b1;
            #1;
            chk("w_ready", WREADY, 1);
            chk("w_ceb", SRAM_CEB, 0);
            chk("w_web", SRAM_WEB, 0);
            chk("w_addr", SRAM_A, wa);
            chk("w_bweb", SRAM_BWEB, nb);
            chk("w_di", SRAM_DI, d);
            for (int k = 0; k < 4; k++)
                if (s[k]) ref_mem[wa][8*k +: 8] = d[8*k +: 8];
            if ((b == wl_beat) != (b == len)) err = 1'b1;
            @(negedge ACLK);
            wa = wa + 14'd1;
        end
        WVALID = 1'b0; WLAST = 1'b0;
        #1;
        chk("b_valid", BVALID, 1);
        chk("b_wready", WREADY, 0);
        chk("b_id", BID, id);
        chk("b_resp", BRESP, err ? 2'b10 : 2'b00);
        last_bresp = BRESP;
        n = $urandom_range(0, 2);
        repeat (n) begin
            @(negedge ACLK); #1;
            chk("b_hold", BVALID, 1);
        end
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0; #1;
        chk("b_done", BVALID, 0);
    endtask

    task automatic do_read(input logic [7:0] id, input logic [31:0] addr,
                           input int len, input int stl_mode,
                           input int abort_at);
        int w, n;
        logic [13:0] wa;
        logic [31:0] hold;
        @(negedge ACLK);
        ARID = id; ARADDR = addr; ARLEN = len[3:0];
        ARSIZE = 3'd2; ARBURST = 2'($urandom); ARVALID = 1'b1;
        #1;
        w = 0;
        while (!ARREADY && w < MAXW) begin
            @(negedge ACLK); #1; w++;
        end
        if (!ARREADY) begin
            chk("arready_timeout", ARREADY, 1);
            ARVALID = 1'b0;
            return;
        end
        if (AWVALID) chk("aw_blocked", AWREADY, 0);
        @(negedge ACLK);
        ARVALID = 1'b0; #1;
        wa = addr[15:2];
        for (int b = 0; b <= len; b++) begin
            w = 0;
            while (!RVALID && w < MAXW) begin
                chk("r_ceb", SRAM_CEB, 0);
                chk("r_web", SRAM_WEB, 1);
                chk("r_addr", SRAM_A, wa);
                @(negedge ACLK); #1; w++;
            end
            if (!RVALID) begin
                chk("rvalid_timeout", RVALID, 1);
                return;
            end
            chk(b == 0 ? "r_first_lat" : "r_gap", w, 1);
            if (b == abort_at) begin
                ARESETn = 1'b0; #1;
                chk("rst_rvalid", RVALID, 0);
                chk("rst_arready", ARREADY, 0);
                chk("rst_ceb", SRAM_CEB, 1);
                @(negedge ACLK);
                ARESETn = 1'b1; #1;
                chk("post_arready", ARREADY, 1);
                repeat (4) begin
                    @(negedge ACLK); #1;
                    chk("post_rvalid", RVALID, 0);
                end
                return;
            end
            chk("r_data", RDATA, ref_mem[wa]);
            chk("r_id", RID, id);
            chk("r_resp", RRESP, 0);
            chk("r_last", RLAST, b == len);
            hold = RDATA;
            last_rdata = RDATA;
            n = (stl_mode == 1) ? stl[b % 4] : $urandom_range(0, 2);
            repeat (n) begin
                @(negedge ACLK); #1;
                chk("r_stall_valid", RVALID, 1);
                chk("r_stall_data", RDATA, hold);
                chk("r_stall_ceb", SRAM_CEB, 1);
            end
            RREADY = 1'b1;
            @(negedge ACLK);
            RREADY = 1'b0; #1;
            wa = wa + 14'd1;
        end
        chk("r_done_idle", ARREADY, 1);
        chk("r_done_rvalid", RVALID, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int len, wl, r;
        logic [31:0] a;
        ARESETn = 1'b0;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0;
        AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WLAST = 1'b0;
        WVALID = 1'b0; BREADY = 1'b0; ARID = '0; ARADDR = '0;
        ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0;
        RREADY = 1'b0;
        repeat (3) @(negedge ACLK);
        #1;
        chk("rst_arready0", ARREADY, 0);
        chk("rst_awready0", AWREADY, 0);
        chk("rst_wready0", WREADY, 0);
        chk("rst_rvalid0", RVALID, 0);
        chk("rst_bvalid0", BVALID, 0);
        chk("rst_rlast0", RLAST, 0);
        chk("rst_rdata0", RDATA, 0);
        chk("rst_rid0", RID, 0);
        chk("rst_bid0", BID, 0);
        chk("rst_resp0", {RRESP, BRESP}, 0);
        chk("rst_ceb0", SRAM_CEB, 1);
        chk("rst_web0", SRAM_WEB, 1);
        chk("rst_bweb0", SRAM_BWEB, 4'hF);
        @(negedge ACLK);
        ARESETn = 1'b1; #1;
        chk("idle_arready", ARREADY, 1);
        chk("idle_awready", AWREADY, 1);

        do_write(8'h5A, 32'h0000_0010, 0, 0, 1, 32'hDEADBEEF, 4'hF, 0);
        do_read(8'h33, 32'h0000_0010, 0, 0, -1);
        chk("rd_deadbeef", last_rdata, 32'hDEADBEEF);

        do_write(8'h01, 32'h0000_0040, 0, 0, 1, 32'h11223344, 4'hF, 0);
        do_write(8'h02, 32'h0000_0040, 0, 0, 1, 32'h0000AB00, 4'h2, 0);
        do_read(8'h03, 32'h0000_0040, 0, 0, -1);
        chk("rd_byte", last_rdata, 32'h1122AB44);

        do_write(8'h04, 32'h0000_0020, 3, 3, 0, 0, 0, 0);
        do_read(8'h05, 32'h0000_0020, 3, 1, -1);

        @(posedge ACLK); #1;
        AWID = 8'h77; AWADDR = 32'h0000_0080; AWLEN = 4'd0;
        AWSIZE = 3'd2; AWBURST = 2'b01; AWVALID = 1'b1;
        do_read(8'h66, 32'h0000_0020, 1, 0, -1);
        chk("aw_after_read", AWREADY, 1);
        do_write(8'h77, 32'h0000_0080, 0, 0, 0, 0, 0, 1);
        chk("aw_wait", aw_wait, 0);

        do_write(8'h08, 32'h0000_0100, 1, 0, 0, 0, 0, 0);
        chk("early_wlast", last_bresp, 2'b10);
        do_read(8'h09, 32'h0000_0100, 1, 0, -1);

        do_write(8'h0A, 32'hABCD_FFFC, 1, 1, 0, 0, 0, 0);
        do_read(8'h0B, 32'h0000_FFFC, 1, 0, -1);
        do_read(8'h0C, 32'h0000_0000, 0, 0, -1);

        do_read(8'h0D, 32'h0000_0020, 3, 0, 1);

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            a[15:2] = ($urandom_range(0, 1) == 0)
                      ? 14'($urandom_range(0, 31))
                      : 14'(16383 - $urandom_range(0, 3));
            len = $urandom_range(0, 5);
            if ($urandom_range(0, 1) == 0) begin
                r = $urandom_range(0, 3);
                wl = (r == 0) ? $urandom_range(0, len)
                   : (r == 1) ? -1 : len;
                do_write(8'($urandom), a, len, wl, 0, 0, 0, 0);
            end else begin
                do_read(8'($urandom), a, len, 0, -1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
